// File: rtl/lcd_host_seq.sv
// rtl/lcd_host_seq.sv - host-side command sequencer and result collector for lcd_ctrl
//
// Walks a command list and issues each code to lcd_ctrl when it is not busy.
// After every load command (code 0) it streams IMG_N image bytes on datain.
// Every dataout beat qualified by output_valid is written to a result memory
// port.
//
// Optional build macro: LCD_HOST_CHECK_EN enables comparison of each captured
// beat against exp_rdata and counts mismatches in err_cnt. Without it, err_cnt
// stays 0 and exp_addr still tracks out_cnt so the ports are identical.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 one-cycle pulse, begins a run from IDLE
//   cmd_addr / cmd_rdata  command list read port (combinational memory)
//   img_addr / img_rdata  image byte read port (combinational memory)
//   cmd, cmd_valid        registered command strobe to lcd_ctrl
//   datain                registered image byte to lcd_ctrl
//   busy                  lcd_ctrl cannot accept a command
//   dataout, output_valid result beats from lcd_ctrl
//   res_we/addr/wdata     result memory write port
//   exp_addr / exp_rdata  expected-data read port, exp_addr = out_cnt
//   out_cnt, err_cnt      captured beats, mismatches
//   done                  run complete, held until next start or reset
//   ovf                   sticky, a beat arrived after OUT_N captures
module lcd_host_seq #(
  parameter int CMD_N = 22,
  parameter int IMG_N = 108,
  parameter int OUT_N = 352
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [4:0] cmd_addr,
  input  logic [2:0] cmd_rdata,
  output logic [6:0] img_addr,
  input  logic [7:0] img_rdata,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  output logic [7:0] datain,
  input  logic       busy,
  input  logic [7:0] dataout,
  input  logic       output_valid,
  output logic       res_we,
  output logic [8:0] res_addr,
  output logic [7:0] res_wdata,
  output logic [8:0] exp_addr,
  input  logic [7:0] exp_rdata,
  output logic [8:0] out_cnt,
  output logic [8:0] err_cnt,
  output logic       done,
  output logic       ovf
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_LOAD,
    S_GAP,
    S_DRAIN
  } state_t;

  localparam logic [4:0] CMD_END  = 5'(CMD_N);
  localparam logic [6:0] IMG_LAST = 7'(IMG_N - 1);
  localparam logic [8:0] OUT_MAX  = 9'(OUT_N);
  localparam logic [8:0] ERR_MAX  = 9'h1FF;

  state_t     state_q, state_d;
  logic [4:0] ci_q, ci_d;
  logic [6:0] k_q, k_d;
  logic [2:0] cmd_q, cmd_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic [7:0] datain_q, datain_d;
  logic       res_we_q, res_we_d;
  logic [8:0] res_addr_q, res_addr_d;
  logic [7:0] res_wdata_q, res_wdata_d;
  logic [8:0] out_cnt_q, out_cnt_d;
  logic [8:0] err_cnt_q, err_cnt_d;
  logic       done_q, done_d;
  logic       ovf_q, ovf_d;

`ifndef LCD_HOST_CHECK_EN
  // Expected data is only consumed by the comparator build.
  logic unused_exp_rdata;
  assign unused_exp_rdata = ^exp_rdata;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: if (!busy) state_d = (cmd_rdata == 3'd0) ? S_LOAD : S_GAP;
      S_LOAD:  if (k_q == IMG_LAST) state_d = S_GAP;
      S_GAP:   state_d = (ci_q == CMD_END) ? S_DRAIN : S_ISSUE;
      S_DRAIN: if (out_cnt_q == OUT_MAX) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic. Strobes and datain default to 0 every cycle,
  // so cmd_valid is a single-cycle pulse and datain only carries a byte on
  // the cycle after each LOAD edge.
  always_comb begin
    ci_d        = ci_q;
    k_d         = k_q;
    cmd_d       = 3'd0;
    cmd_valid_d = 1'b0;
    datain_d    = 8'd0;
    res_we_d    = 1'b0;
    res_addr_d  = res_addr_q;
    res_wdata_d = res_wdata_q;
    out_cnt_d   = out_cnt_q;
    err_cnt_d   = err_cnt_q;
    done_d      = done_q;
    ovf_d       = ovf_q;

    case (state_q)
      S_ISSUE: begin
        if (!busy) begin
          cmd_d       = cmd_rdata;
          cmd_valid_d = 1'b1;
          ci_d        = ci_q + 5'd1;
        end
      end
      S_LOAD: begin
        datain_d = img_rdata;
        k_d      = (k_q == IMG_LAST) ? 7'd0 : k_q + 7'd1;
      end
      S_DRAIN: begin
        if (out_cnt_q == OUT_MAX) done_d = 1'b1;
      end
      default: ;
    endcase

    // A start clears the run counters; a beat on that same cycle is dropped
    // so the result index restarts cleanly at 0.
    if (state_q == S_IDLE && start) begin
      ci_d      = 5'd0;
      out_cnt_d = 9'd0;
      err_cnt_d = 9'd0;
      done_d    = 1'b0;
      ovf_d     = 1'b0;
    end else if (output_valid) begin
      if (out_cnt_q < OUT_MAX) begin
        res_we_d    = 1'b1;
        res_addr_d  = out_cnt_q;
        res_wdata_d = dataout;
        out_cnt_d   = out_cnt_q + 9'd1;
`ifdef LCD_HOST_CHECK_EN
        if (dataout != exp_rdata && err_cnt_q != ERR_MAX) begin
          err_cnt_d = err_cnt_q + 9'd1;
        end
`endif
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ci_q        <= 5'd0;
      k_q         <= 7'd0;
      cmd_q       <= 3'd0;
      cmd_valid_q <= 1'b0;
      datain_q    <= 8'd0;
      res_we_q    <= 1'b0;
      res_addr_q  <= 9'd0;
      res_wdata_q <= 8'd0;
      out_cnt_q   <= 9'd0;
      err_cnt_q   <= 9'd0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      ci_q        <= ci_d;
      k_q         <= k_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      datain_q    <= datain_d;
      res_we_q    <= res_we_d;
      res_addr_q  <= res_addr_d;
      res_wdata_q <= res_wdata_d;
      out_cnt_q   <= out_cnt_d;
      err_cnt_q   <= err_cnt_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  assign cmd_addr  = ci_q;
  assign img_addr  = k_q;
  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign datain    = datain_q;
  assign res_we    = res_we_q;
  assign res_addr  = res_addr_q;
  assign res_wdata = res_wdata_q;
  assign exp_addr  = out_cnt_q;
  assign out_cnt   = out_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign done      = done_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_lcd_host_seq.sv
// tb/tb_lcd_host_seq.sv - self-checking bench for lcd_host_seq
module tb_lcd_host_seq;

  localparam int CMD_N = 22;
  localparam int IMG_N = 108;
  localparam int OUT_N = 352;
`ifdef LCD_HOST_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy = 1'b0;
  logic       output_valid = 1'b0;
  logic [7:0] dataout = 8'd0;
  logic [4:0] cmd_addr;
  logic [2:0] cmd_rdata;
  logic [6:0] img_addr;
  logic [7:0] img_rdata;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [7:0] datain;
  logic       res_we;
  logic [8:0] res_addr;
  logic [7:0] res_wdata;
  logic [8:0] exp_addr;
  logic [7:0] exp_rdata;
  logic [8:0] out_cnt;
  logic [8:0] err_cnt;
  logic       done;
  logic       ovf;

  logic [2:0] cmd_mem [0:31];
  logic [7:0] img_mem [0:127];
  logic [7:0] exp_mem [0:511];
  logic [7:0] res_mem [0:511];
  logic [7:0] beat_log [0:511];

  assign cmd_rdata = cmd_mem[cmd_addr];
  assign img_rdata = img_mem[img_addr];
  assign exp_rdata = exp_mem[exp_addr];

  lcd_host_seq #(.CMD_N(CMD_N), .IMG_N(IMG_N), .OUT_N(OUT_N)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cmd_addr(cmd_addr), .cmd_rdata(cmd_rdata),
    .img_addr(img_addr), .img_rdata(img_rdata),
    .cmd(cmd), .cmd_valid(cmd_valid), .datain(datain), .busy(busy),
    .dataout(dataout), .output_valid(output_valid),
    .res_we(res_we), .res_addr(res_addr), .res_wdata(res_wdata),
    .exp_addr(exp_addr), .exp_rdata(exp_rdata),
    .out_cnt(out_cnt), .err_cnt(err_cnt), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model for the random run: the command list is the sequence of
  // strobes, every load strobe is followed by IMG_N image bytes, and beats are
  // numbered in arrival order up to OUT_N, after which they only raise ovf.
  bit   mon_en = 1'b0;
  bit   busy_at_edge;
  int   model_cnt, model_err;
  bit   model_ovf, exp_we;
  int   exp_waddr, exp_wd;
  int   issue_idx, stream_left;
  int   strobe_cyc [0:31];

  always @(posedge clk) begin
    busy_at_edge <= busy;
    if (!mon_en) begin
      model_cnt <= 0;
      model_err <= 0;
      model_ovf <= 1'b0;
      exp_we    <= 1'b0;
    end else if (output_valid) begin
      if (model_cnt < OUT_N) begin
        exp_we    <= 1'b1;
        exp_waddr <= model_cnt;
        exp_wd    <= int'(dataout);
        model_cnt <= model_cnt + 1;
        if (CHK == 1 && dataout != exp_mem[model_cnt]) model_err <= model_err + 1;
      end else begin
        exp_we    <= 1'b0;
        model_ovf <= 1'b1;
      end
    end else begin
      exp_we <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!mon_en) begin
      issue_idx   <= 0;
      stream_left <= 0;
    end else begin
      if (stream_left > 0) chk("datain_stream", datain, img_mem[IMG_N - stream_left]);
      else                 chk("datain_quiet", datain, 0);
      if (cmd_valid) begin
        chk("strobe_busy_clear", busy_at_edge, 0);
        chk("strobe_not_in_stream", stream_left, 0);
        chk("strobe_in_range", int'(issue_idx < CMD_N), 1);
        if (issue_idx < CMD_N) begin
          chk("strobe_cmd", cmd, cmd_mem[issue_idx]);
          strobe_cyc[issue_idx] <= cyc;
          stream_left <= (cmd_mem[issue_idx] == 3'd0) ? IMG_N : 0;
        end
        issue_idx <= issue_idx + 1;
      end else begin
        chk("cmd_quiet", cmd, 0);
        if (stream_left > 0) stream_left <= stream_left - 1;
      end
      chk("res_we", res_we, exp_we);
      if (exp_we) begin
        chk("res_addr", res_addr, exp_waddr);
        chk("res_wdata", res_wdata, exp_wd);
      end
      if (res_we) res_mem[res_addr] <= res_wdata;
      chk("out_cnt", out_cnt, model_cnt);
      chk("exp_addr", exp_addr, model_cnt);
      chk("ovf", ovf, model_ovf);
      chk("err_cnt", err_cnt, model_err);
      if (done) chk("done_only_when_complete",
                    int'(issue_idx == CMD_N && model_cnt == OUT_N && stream_left == 0), 1);
    end
  end

  typedef struct {
    logic       ov;
    logic [7:0] dout;
    logic       we;
    int         addr;
    int         wd;
    int         cnt;
    int         err;
  } vec_t;

  vec_t tbl [0:6];

  initial begin
    int beats, hold, start_cyc, n;
    bit fin;

    tbl[0] = '{1'b0, 8'h00, 1'b0, 0, 0,    0, 0};
    tbl[1] = '{1'b1, 8'h11, 1'b1, 0, 'h11, 1, 0};
    tbl[2] = '{1'b1, 8'h22, 1'b1, 1, 'h22, 2, 0};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 0, 0,    2, 0};
    tbl[4] = '{1'b1, 8'h35, 1'b1, 2, 'h35, 3, 1};
    tbl[5] = '{1'b1, 8'h44, 1'b1, 3, 'h44, 4, 1};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 0, 0,    4, 1};

    for (int i = 0; i < 32; i++)  cmd_mem[i] = 3'd0;
    for (int i = 0; i < 128; i++) img_mem[i] = 8'(i);
    for (int i = 0; i < 512; i++) exp_mem[i] = 8'd0;
    exp_mem[0] = 8'h11; exp_mem[1] = 8'h22; exp_mem[2] = 8'h33; exp_mem[3] = 8'h44;

    // Reset, then idle with no start: every output must stay 0.
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_cmd_valid", cmd_valid, 0);
      chk("idle_outputs_zero",
          int'(|{cmd, datain, cmd_addr, img_addr, res_we, res_addr, res_wdata,
                 exp_addr, out_cnt, err_cnt, done, ovf}), 0);
    end

    // Capture works from IDLE too: table of beats with expected write port.
    for (int i = 0; i < 7; i++) begin
      output_valid = tbl[i].ov;
      dataout      = tbl[i].dout;
      step();
      chk("tbl_res_we", res_we, tbl[i].we);
      if (tbl[i].we) begin
        chk("tbl_res_addr", res_addr, tbl[i].addr);
        chk("tbl_res_wdata", res_wdata, tbl[i].wd);
      end
      chk("tbl_out_cnt", out_cnt, tbl[i].cnt);
      chk("tbl_exp_addr", exp_addr, tbl[i].cnt);
      chk("tbl_err_cnt", err_cnt, CHK * tbl[i].err);
      chk("tbl_ovf", ovf, 0);
      chk("tbl_cmd_valid", cmd_valid, 0);
    end
    output_valid = 1'b0;

    // Start clears counters, then a load command streams bytes; reset at k=50.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_clears_out_cnt", out_cnt, 0);
    chk("start_clears_err_cnt", err_cnt, 0);
    chk("start_cmd_addr", cmd_addr, 0);
    n = 0;
    while (!cmd_valid && n < 10) begin
      step();
      n++;
    end
    chk("load_strobe_seen", cmd_valid, 1);
    chk("load_strobe_latency", n, 1);
    chk("load_cmd", cmd, 0);
    for (int j = 0; j < 50; j++) begin
      step();
      chk("load_datain", datain, j);
      chk("load_no_strobe", cmd_valid, 0);
    end
    chk("load_k50", img_addr, 50);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_datain", datain, 0);
    chk("abort_cmd_valid", cmd_valid, 0);
    chk("abort_img_addr", img_addr, 0);
    chk("abort_cmd_addr", cmd_addr, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_stays_idle", int'(cmd_valid | (|datain)), 0);
    end

    // Randomized full run checked against the reference model.
    cmd_mem[0] = 3'd1;
    cmd_mem[1] = 3'd2;
    for (int i = 2; i < CMD_N; i++)
      cmd_mem[i] = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
    cmd_mem[5] = 3'd0;
    for (int i = 0; i < 128; i++) img_mem[i] = 8'($urandom);
    for (int i = 0; i < 512; i++) exp_mem[i] = 8'($urandom);

    mon_en = 1'b1;
    step();
    start = 1'b1;
    start_cyc = cyc;
    step();
    start = 1'b0;
    beats = 0;
    hold = 0;
    fin = 1'b0;
    for (n = 0; n < 8000 && !fin; n++) begin
      // busy held high for 5 cycles after each strobe; random once two
      // commands have gone out.
      if (hold > 0) begin
        busy = 1'b1;
        hold--;
      end else begin
        busy = (issue_idx >= 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      if (cmd_valid) hold = 5;
      start = (n == 50);
      if (n != 50 && beats < OUT_N + 3 && $urandom_range(0, 1) == 1) begin
        output_valid = 1'b1;
        dataout = ($urandom_range(0, 1) == 1) ? exp_mem[beats] : 8'($urandom);
        beat_log[beats] = dataout;
        beats++;
      end else begin
        output_valid = 1'b0;
      end
      step();
      fin = done && beats >= OUT_N + 3 && !output_valid;
    end
    start = 1'b0;
    busy = 1'b0;
    output_valid = 1'b0;
    step();
    step();

    chk("run_finished", int'(fin), 1);
    chk("run_issued_all", issue_idx, CMD_N);
    chk("run_start_latency", strobe_cyc[0] - start_cyc, 2);
    chk("run_busy_spacing", strobe_cyc[1] - strobe_cyc[0], 7);
    chk("run_out_cnt", out_cnt, OUT_N);
    chk("run_ovf", ovf, 1);
    chk("run_done", done, 1);
    chk("run_err_cnt", err_cnt, model_err);
    for (int i = 0; i < OUT_N; i++) chk("run_res_mem", res_mem[i], beat_log[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
